// File: rtl/uart_tx_framer.sv
// Buffered UART transmitter: small byte FIFO feeding an 8-bit LSB-first
// serialiser with optional even/odd parity and one or two stop bits.
module uart_tx_framer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [3:0] mode,
  output logic       tx_line,
  output logic       busy
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_CLKS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      mode_q, mode_d;
  logic            par_q, par_d;
  logic            stop2_q, stop2_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;

  logic            push;
  logic            pop;
  logic            empty;
  logic            cnt_zero;
  logic            unused_mode;

  // mode[3] is reserved and deliberately has no effect
  assign unused_mode = mode[3];

  assign empty      = (count_q == '0);
  assign data_ready = (count_q != FULL_CNT);
  assign push       = data_valid && data_ready;
  assign cnt_zero   = (cnt_q == '0);

  assign tx_line = tx_q;
  assign busy    = (state_q != IDLE) || !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    tx_d    = 1'b1;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          mode_d  = mode[2:0];
          par_d   = 1'b0;
          stop2_d = 1'b0;
          cnt_d   = CNT_MAX;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_zero) begin
          cnt_d   = CNT_MAX;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (cnt_zero) begin
          cnt_d   = CNT_MAX;
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = mode_q[0] ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PARITY: begin
        // running XOR of the data bits, inverted for odd parity
        tx_d = par_q ^ mode_q[1];
        if (cnt_zero) begin
          cnt_d   = CNT_MAX;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_zero) begin
          if (mode_q[2] && !stop2_q) begin
            stop2_d = 1'b1;
            cnt_d   = CNT_MAX;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // tx follows the current state one cycle later, so the line is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mode_q  <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomised bench for uart_tx_framer: a queue of expected frames is
// expanded into ideal line bits and compared cycle by cycle against tx_line.
module tb_uart_tx_framer;

  localparam int B = 50000000 / 115200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [3:0] mode = '0;
  logic       tx_line;
  logic       busy;

  uart_tx_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .mode       (mode),
    .tx_line    (tx_line),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] m;
  } frame_t;

  frame_t exp_q[$];

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int starts = 0;
  int frames_done = 0;
  int last_start = 0;
  int prev_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // monitor: ideal frame from plain arithmetic, compared every cycle
  logic   mbits [12];
  int     nb = 0;
  int     bi = 0;
  int     bc = 0;
  int     tot = 0;
  logic   mon_on = 1'b0;
  logic   spur = 1'b0;
  logic   bad = 1'b0;
  logic   badv = 1'b0;
  frame_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_on = 1'b0;
      spur   = 1'b0;
    end else begin
      if (!mon_on) begin
        if (tx_line === 1'b0) begin
          if (exp_q.size() == 0) begin
            if (!spur) expect_eq("spurious_start", 0, 1);
            spur = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            mbits[0] = 1'b0;
            for (int i = 0; i < 8; i++) mbits[1+i] = cur.b[i];
            nb = 9;
            if (cur.m[0]) begin
              mbits[nb] = (($countones(cur.b) % 2) == 1) ^ cur.m[1];
              nb = nb + 1;
            end
            mbits[nb] = 1'b1;
            nb = nb + 1;
            if (cur.m[2]) begin
              mbits[nb] = 1'b1;
              nb = nb + 1;
            end
            mon_on = 1'b1;
            bi = 0;
            bc = 0;
            tot = 0;
            bad = 1'b0;
            prev_start = last_start;
            last_start = cyc;
            starts++;
          end
        end else begin
          spur = 1'b0;
        end
      end
      if (mon_on) begin
        if (tx_line !== mbits[bi] && !bad) begin
          bad  = 1'b1;
          badv = tx_line;
        end
        if (tot == nb * B - 2) expect_eq("busy_in_frame", busy, 1);
        if (tot == nb * B - 1)
          expect_eq("busy_after_frame", busy, exp_q.size() != 0);
        tot++;
        bc++;
        if (bc == B) begin
          expect_eq($sformatf("frame%0d_bit%0d", starts, bi),
                    bad ? badv : mbits[bi], mbits[bi]);
          bc  = 0;
          bad = 1'b0;
          bi++;
          if (bi == nb) begin
            mon_on = 1'b0;
            frames_done++;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic [3:0] m);
    int n = 0;
    @(negedge clk);
    mode = m;
    data_in = b;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && n < 20 * B) begin
      @(negedge clk);
      n++;
    end
    expect_eq("push_ready", data_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    exp_q.push_back('{b, m});
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_start(input int target);
    int n = 0;
    while (starts < target && n < 20 * B) begin
      @(negedge clk);
      n++;
    end
    expect_eq("start_seen", starts, target);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < 80 * B) begin
      @(negedge clk);
      n++;
    end
    expect_eq("frames_done", frames_done, target);
  endtask

  initial begin
    logic       o_tx;
    logic       o_busy;
    logic       o_rdy;
    logic [7:0] rb;
    logic [3:0] rm;
    int         s0;

    // reset and idle
    repeat (3) @(negedge clk);
    expect_eq("rst_tx", tx_line, 1);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_ready", data_ready, 1);
    rst_n = 1'b1;
    o_tx = 1'b1;
    o_busy = 1'b0;
    o_rdy = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (tx_line !== 1'b1) o_tx = tx_line;
      if (busy !== 1'b0) o_busy = busy;
      if (data_ready !== 1'b1) o_rdy = data_ready;
    end
    expect_eq("idle_tx", o_tx, 1);
    expect_eq("idle_busy", o_busy, 0);
    expect_eq("idle_ready", o_rdy, 1);

    // 8N1 and start latency
    push(8'h55, 4'd0);
    wait_start(1);
    expect_eq("latency", last_start - acc_cyc, 2);
    wait_done(1);

    // parity variants
    push(8'hA7, 4'd1);
    wait_done(2);
    push(8'hA7, 4'd3);
    wait_done(3);
    push(8'h00, 4'd5);
    wait_done(4);

    // FIFO fill, refusal and back-to-back frames
    s0 = starts;
    mode = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      data_in = 8'(k);
      data_valid = 1'b1;
      expect_eq($sformatf("fill_ready_%0d", k), data_ready, k <= 5);
      if (data_ready) exp_q.push_back('{8'(k), 4'd0});
    end
    @(negedge clk);
    data_valid = 1'b0;
    expect_eq("full_hold", data_ready, 0);
    for (int j = 2; j <= 5; j++) begin
      wait_start(s0 + j);
      expect_eq($sformatf("gap_%0d", j), last_start - prev_start, 10 * B + 1);
      if (j == 2) expect_eq("ready_after_pop", data_ready, 1);
    end
    wait_done(frames_done + 1);

    // write landing on the pop edge
    s0 = starts;
    push(8'h81, 4'd0);
    push(8'h42, 4'd0);
    wait_start(s0 + 1);
    while (cyc < last_start + 10 * B - 1) @(negedge clk);
    data_in = 8'h99;
    data_valid = 1'b1;
    expect_eq("simul_ready", data_ready, 1);
    @(posedge clk);
    #1;
    exp_q.push_back('{8'h99, 4'd0});
    @(negedge clk);
    data_valid = 1'b0;
    expect_eq("simul_ready_after", data_ready, 1);
    wait_start(s0 + 3);
    expect_eq("simul_gap", last_start - prev_start, 10 * B + 1);
    wait_done(frames_done + 1);

    // reset during data bit 3 with two bytes queued
    s0 = starts;
    push(8'hF0, 4'd0);
    push(8'h11, 4'd0);
    push(8'h22, 4'd0);
    wait_start(s0 + 1);
    while (cyc < last_start + 4 * B + B / 2) @(negedge clk);
    expect_eq("pre_rst_tx", tx_line, 0);
    #5;
    rst_n = 1'b0;
    #1;
    expect_eq("async_tx", tx_line, 1);
    expect_eq("async_busy", busy, 0);
    expect_eq("async_ready", data_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    o_tx = 1'b1;
    o_busy = 1'b0;
    repeat (B) begin
      @(negedge clk);
      if (tx_line !== 1'b1) o_tx = tx_line;
      if (busy !== 1'b0) o_busy = busy;
    end
    expect_eq("post_rst_tx", o_tx, 1);
    expect_eq("post_rst_busy", o_busy, 0);
    push(8'h3C, 4'd0);
    wait_done(frames_done + 1);

    // random frames with a mode change once each frame is under way
    for (int r = 0; r < 2; r++) begin
      rb = 8'($urandom);
      rm = 4'($urandom_range(0, 15));
      s0 = starts;
      push(rb, rm);
      wait_start(s0 + 1);
      mode = rm ^ 4'b0111;
      wait_done(frames_done + 1);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
